// File: rtl/piso_word_tx_if.sv
// Word-in / bit-out bus of the PISO word transmitter.
// The slave modport is the transmitter itself; the master modport is the word source and SIPO side.
interface piso_word_tx_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] Din;
    logic             Valid;
    logic             Ready;
    logic             SerialOut;
    logic             SHIFT;
    logic             WordDone;
    logic             Busy;

    modport master (
        output Din,
        output Valid,
        input  Ready,
        input  SerialOut,
        input  SHIFT,
        input  WordDone,
        input  Busy
    );

    modport slave (
        input  Din,
        input  Valid,
        output Ready,
        output SerialOut,
        output SHIFT,
        output WordDone,
        output Busy
    );
endinterface

// File: rtl/piso_word_tx.sv
// Parallel-in serial-out word transmitter: accepts a word on Valid/Ready, shifts it out LSB first
// with a SHIFT strobe, then pulses WordDone once the downstream SIPO holds the full word.
module piso_word_tx #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned GAP   = 0
) (
    input logic           CLK,
    input logic           CLR_N,
    piso_word_tx_if.slave bus
);

    localparam int unsigned CntMax = (WIDTH > GAP) ? WIDTH : GAP;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] SendLast = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] GapLast  = (GAP > 0) ? CntW'(GAP - 1) : '0;

    typedef enum logic [1:0] {StIdle, StSend, StDone, StGap} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             ser_q, ser_d;
    logic             shift_q, shift_d;
    logic             done_q, done_d;
    logic             accept;

    // Ready is only ever high in IDLE, so this is the full handshake.
    assign accept = bus.Valid && ready_q;

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StSend;
                    sreg_d  = bus.Din;
                    cnt_d   = '0;
                end
            end
            StSend: begin
                sreg_d = sreg_q >> 1;
                if (cnt_q == SendLast) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                cnt_d = '0;
                if (GAP == 0) begin
                    state_d = StIdle;
                end else begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered, so they are decoded from the next state.
    always_comb begin
        ready_d = 1'b0;
        ser_d   = 1'b0;
        shift_d = 1'b0;
        done_d  = 1'b0;
        unique case (state_d)
            StIdle: ready_d = 1'b1;
            StSend: begin
                shift_d = 1'b1;
                ser_d   = sreg_d[0];
            end
            StDone: done_d = 1'b1;
            StGap:  ready_d = 1'b0;
            default: ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            sreg_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            ser_q   <= 1'b0;
            shift_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            ser_q   <= ser_d;
            shift_q <= shift_d;
            done_q  <= done_d;
        end
    end

    assign bus.Ready     = ready_q;
    assign bus.SerialOut = ser_q;
    assign bus.SHIFT     = shift_q;
    assign bus.WordDone  = done_q;
    assign bus.Busy      = (state_q != StIdle);

endmodule
